// File: rtl/ram_responder.sv
// ram_responder: single-port register-file RAM behind a request/response
// valid-ready handshake, with WAIT_CYCLES programmable wait states.
// One transaction in flight at a time; req_ready is high only in IDLE.
// Optional: define RAM_RESPONDER_STATS_EN to add wr_count/rd_count ports
// counting completed write/read response handshakes.
module ram_responder #(
    parameter int ADDR_W      = 3,
    parameter int DATA_W      = 8,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_wr,
    output logic [DATA_W-1:0] rdata
`ifdef RAM_RESPONDER_STATS_EN
    ,
    output logic [15:0]       wr_count,
    output logic [15:0]       rd_count
`endif
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        cnt;
    logic [3:0]        cnt_nxt;
    logic              accept;
    logic              load_rsp;
    logic              rsp_done;
    logic              lat_wr;
    logic [ADDR_W-1:0] lat_addr;
    logic              src_wr;
    logic [ADDR_W-1:0] src_addr;
    logic [DATA_W-1:0] mem [DEPTH];

    assign req_ready = (state == S_IDLE);
    assign accept    = req_valid & req_ready;
    assign rsp_done  = rsp_valid & rsp_ready;

    // With no wait states the response is built on the accept edge itself,
    // so it must come straight from the request inputs rather than the latches.
    assign src_wr   = (state == S_IDLE) ? wr   : lat_wr;
    assign src_addr = (state == S_IDLE) ? addr : lat_addr;

    // State and wait-counter registers.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state decode, counter update and response-load strobe.
    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        load_rsp  = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (WAIT_CYCLES > 0) begin
                        state_nxt = S_WAIT;
                        cnt_nxt   = WAIT_LOAD;
                    end else begin
                        state_nxt = S_RESP;
                        load_rsp  = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (cnt == 4'd0) begin
                    state_nxt = S_RESP;
                    load_rsp  = 1'b1;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Request latches and registered response outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lat_wr    <= 1'b0;
            lat_addr  <= '0;
            rsp_valid <= 1'b0;
            rsp_wr    <= 1'b0;
            rdata     <= '0;
        end else begin
            if (accept) begin
                lat_wr   <= wr;
                lat_addr <= addr;
            end
            if (load_rsp) begin
                rsp_valid <= 1'b1;
                rsp_wr    <= src_wr;
                rdata     <= src_wr ? '0 : mem[src_addr];
            end else if (state == S_RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
                rsp_wr    <= 1'b0;
                rdata     <= '0;
            end
        end
    end

    // Memory array: written on the accept edge of a write request.
    // NOTE: the array is deliberately reset, since reads after reset must return 0;
    // this forces flops rather than a RAM macro, acceptable at this small depth.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (accept && wr) begin
            mem[addr] <= wdata;
        end
    end

`ifdef RAM_RESPONDER_STATS_EN
    // Completed-transaction counters, bumped on the response handshake edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_count <= 16'd0;
            rd_count <= 16'd0;
        end else if (rsp_done) begin
            if (rsp_wr) begin
                wr_count <= wr_count + 16'd1;
            end else begin
                rd_count <= rd_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ram_responder.sv
// tb_ram_responder: drives two responders (WAIT_CYCLES = 0 and 3) one
// transaction at a time; expected responses come from a per-instance memory
// array and go into a scoreboard queue that a negedge monitor drains.
module tb_ram_responder;

    typedef struct {
        int         dut;
        logic       wr;
        logic [7:0] rdata;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req_valid [2];
    logic       req_ready [2];
    logic       wr        [2];
    logic [2:0] addr      [2];
    logic [7:0] wdata     [2];
    logic       rsp_valid [2];
    logic       rsp_ready [2];
    logic       rsp_wr    [2];
    logic [7:0] rdata     [2];
`ifdef RAM_RESPONDER_STATS_EN
    logic [15:0] wr_count [2];
    logic [15:0] rd_count [2];
`endif

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   acc_cyc  [2];
    int   acc_cnt  [2];
    exp_t sb_q     [$];
    logic [7:0] model_mem [2][8];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        ram_responder #(.ADDR_W(3), .DATA_W(8), .WAIT_CYCLES(g * 3)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .req_valid (req_valid[g]),
            .req_ready (req_ready[g]),
            .wr        (wr[g]),
            .addr      (addr[g]),
            .wdata     (wdata[g]),
            .rsp_valid (rsp_valid[g]),
            .rsp_ready (rsp_ready[g]),
            .rsp_wr    (rsp_wr[g]),
            .rdata     (rdata[g])
`ifdef RAM_RESPONDER_STATS_EN
            ,
            .wr_count  (wr_count[g]),
            .rd_count  (rd_count[g])
`endif
        );
    end

    function automatic int wait_of(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One step: just after a rising edge, when DUT outputs have settled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++)
            for (int a = 0; a < 8; a++)
                model_mem[d][a] = 8'd0;
        sb_q.delete();
    endtask

    // Present a request, record the expected response, update the model.
    task automatic present(input int d, input logic w, input logic [2:0] a, input logic [7:0] v);
        exp_t e;
        e.dut = d;
        e.wr  = w;
        e.rdata = w ? 8'd0 : model_mem[d][a];
        if (w) model_mem[d][a] = v;
        sb_q.push_back(e);
        req_valid[d] = 1'b1;
        wr[d]        = w;
        addr[d]      = a;
        wdata[d]     = v;
    endtask

    task automatic wait_accept(input int d);
        bit done = 0;
        for (int i = 0; i < 200; i++) begin
            if (req_ready[d]) begin
                tick();
                done = 1;
                break;
            end
            tick();
        end
        req_valid[d] = 1'b0;
        wr[d]        = $urandom_range(0, 1);
        addr[d]      = 3'($urandom);
        wdata[d]     = 8'($urandom);
        check("accept_timeout", done, 1);
    endtask

    // Run the response phase: hold rsp_ready low for bp cycles of rsp_valid,
    // then handshake; returns once req_ready comes back.
    task automatic finish(input int d, input int bp);
        int  bp_left = bp;
        int  busy = 0;
        bit  got = 0;
        for (int i = 0; i < 200; i++) begin
            if (req_ready[d]) begin
                got = 1;
                break;
            end
            busy++;
            if (rsp_valid[d]) begin
                if (bp_left == 0) rsp_ready[d] = 1'b1;
                else bp_left--;
            end
            tick();
        end
        rsp_ready[d] = 1'b0;
        check("response_timeout", got, 1);
        check("busy_cycles", busy, wait_of(d) + 1 + bp);
    endtask

    task automatic do_txn(input int d, input logic w, input logic [2:0] a, input logic [7:0] v, input int bp);
        present(d, w, a, v);
        rsp_ready[d] = 1'b0;
        wait_accept(d);
        finish(d, bp);
    endtask

    // Cycle counter for latency measurement (read only at negedge).
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: accept tracking, latency, backpressure stability, scoreboard.
    initial begin
        logic       prev_valid [2];
        logic       prev_ready [2];
        logic       prev_wr    [2];
        logic [7:0] prev_rdata [2];
        exp_t       e;
        for (int d = 0; d < 2; d++) begin
            prev_valid[d] = 0; prev_ready[d] = 0; prev_wr[d] = 0; prev_rdata[d] = 0;
            acc_cnt[d] = 0; acc_cyc[d] = 0;
        end
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (!rst) begin
                    prev_valid[d] = 1'b0;
                    continue;
                end
                if (req_valid[d] && req_ready[d]) begin
                    acc_cyc[d] = cyc + 1;
                    acc_cnt[d]++;
                end
                if (rsp_valid[d] && !prev_valid[d])
                    check("rsp_latency", cyc - acc_cyc[d] + 1, wait_of(d) + 1);
                if (prev_valid[d] && !prev_ready[d]) begin
                    check("hold_valid", rsp_valid[d], 1);
                    check("hold_rdata", rdata[d], prev_rdata[d]);
                    check("hold_rsp_wr", rsp_wr[d], prev_wr[d]);
                end
                if (rsp_valid[d] && rsp_ready[d]) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_rsp", 1, 0);
                    end else begin
                        e = sb_q.pop_front();
                        check("rsp_dut", d, e.dut);
                        check("rsp_wr", rsp_wr[d], e.wr);
                        check("rsp_rdata", rdata[d], e.rdata);
                    end
                end
                prev_valid[d] = rsp_valid[d];
                prev_ready[d] = rsp_ready[d];
                prev_wr[d]    = rsp_wr[d];
                prev_rdata[d] = rdata[d];
            end
        end
    end

    initial begin
        logic [7:0] wr_vals [4];
        logic [2:0] wr_addr [4];
        logic [2:0] rd_addr [5];
        int         acc_before;
        wr_vals = '{8'd10, 8'd20, 8'd30, 8'd40};
        wr_addr = '{3'd0, 3'd1, 3'd3, 3'd4};
        rd_addr = '{3'd0, 3'd1, 3'd3, 3'd4, 3'd2};

        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0; wr[d] = 1'b0; addr[d] = '0; wdata[d] = '0; rsp_ready[d] = 1'b0;
        end
        model_reset();

        // Reset state.
        tick();
        for (int d = 0; d < 2; d++) begin
            check("reset_rsp_valid", rsp_valid[d], 0);
            check("reset_rdata", rdata[d], 0);
            check("reset_rsp_wr", rsp_wr[d], 0);
        end
        tick();
        rst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) check("reset_req_ready", req_ready[d], 1);

        // Writes then reads with no wait states.
        for (int i = 0; i < 4; i++) do_txn(0, 1'b1, wr_addr[i], wr_vals[i], 0);
        for (int i = 0; i < 5; i++) do_txn(0, 1'b0, rd_addr[i], 8'd0, 0);
`ifdef RAM_RESPONDER_STATS_EN
        check("wr_count_after_s1", wr_count[0], 4);
        check("rd_count_after_s1", rd_count[0], 5);
`endif

        // Wait states, top address.
        do_txn(1, 1'b1, 3'd7, 8'hA5, 0);
        do_txn(1, 1'b0, 3'd7, 8'd0, 0);

        // Backpressure: read 3 held for 5 cycles.
        do_txn(0, 1'b0, 3'd3, 8'd0, 5);

        // Request held while a prior response is stalled.
        present(0, 1'b0, 3'd3, 8'd0);
        rsp_ready[0] = 1'b0;
        wait_accept(0);
        acc_before = acc_cnt[0];
        present(0, 1'b1, 3'd5, 8'd99);
        finish(0, 3);
        check("held_not_early", acc_cnt[0], acc_before);
        wait_accept(0);
        finish(0, 0);
        check("held_accept_once", acc_cnt[0], acc_before + 1);
        do_txn(0, 1'b0, 3'd5, 8'd0, 0);

        // Randomized traffic on both instances.
        for (int i = 0; i < 60; i++) begin
            do_txn($urandom_range(0, 1), 1'($urandom_range(0, 1)), 3'($urandom),
                   8'($urandom), $urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) tick();
        end

        // Reset in WAIT: write to 2 is lost.
        do_txn(1, 1'b1, 3'd6, 8'h3C, 0);
        present(1, 1'b1, 3'd2, 8'd55);
        rsp_ready[1] = 1'b0;
        wait_accept(1);
        tick();
        rst = 1'b0;
        #1;
        check("midreset_rsp_valid", rsp_valid[1], 0);
        check("midreset_req_ready", req_ready[1], 1);
        req_valid[0] = 1'b0; req_valid[1] = 1'b0;
        model_reset();
        tick();
        rst = 1'b1;
        #1;
`ifdef RAM_RESPONDER_STATS_EN
        for (int d = 0; d < 2; d++) begin
            check("wr_count_reset", wr_count[d], 0);
            check("rd_count_reset", rd_count[d], 0);
        end
`endif
        do_txn(1, 1'b0, 3'd2, 8'd0, 0);
        do_txn(1, 1'b0, 3'd6, 8'd0, 0);

        tick();
        tick();
        check("scoreboard_drained", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram_responder.md
Name: ram_responder

Overview:
- Memory-side responder for the single-port RAM access interface: an 8-bit wide, 2**ADDR_W deep register-file RAM.
- Sits behind an initiator, either a bench driver or an RTL master, and serves one read or write at a time.
- Uses a request valid/ready handshake and a response valid/ready handshake.
- Programmable wait states model slow memory.

Parameters:
- ADDR_W, 3, address width; DEPTH = 2**ADDR_W entries.
- DATA_W, 8, data width.
- WAIT_CYCLES, 0, extra cycles between request accept and response; range 0..15.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- req_valid  input  1  initiator presents a request.
- req_ready  output  1  responder can accept a request.
- wr  input  1  1 = write, 0 = read; sampled with the request.
- addr  input  ADDR_W  word address; sampled with the request.
- wdata  input  DATA_W  write data; sampled with the request.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  initiator accepts the response.
- rsp_wr  output  1  echoes wr of the request being answered.
- rdata  output  DATA_W  read data; 0 for write responses.

Behaviour:
- Reset (rst=0, asynchronous):
  - State = IDLE, wait counter = 0.
  - All DEPTH memory entries = 0.
  - rdata = 0, rsp_valid = 0, rsp_wr = 0.
  - req_ready = 1 as soon as rst deasserts.
- Request accept: a request is accepted on a rising edge where req_valid=1 and req_ready=1. wr, addr and wdata are latched on that edge.
- req_ready = 1 only in IDLE; it is a combinational decode of state.
- req_valid/wr/addr/wdata are ignored while req_ready=0. The initiator holds them until accepted.
- Write: mem[addr] <= wdata on the accept edge. A read issued afterwards always returns the new value.
- State machine:
  - IDLE: on accept, go to WAIT if WAIT_CYCLES>0 and load the counter with WAIT_CYCLES-1; otherwise go to RESP.
  - WAIT: counter decrements each cycle; go to RESP on the edge where the counter = 0.
  - RESP: rsp_valid=1. rdata = mem[latched addr] for reads, 0 for writes; rsp_wr = latched wr. These are registered on the edge entering RESP.
  - RESP exit: on the edge with rsp_ready=1, go to IDLE and clear rsp_valid/rdata/rsp_wr to 0.
- Latency: rsp_valid rises WAIT_CYCLES+1 cycles after the accept edge. With WAIT_CYCLES=0, it is high in the cycle immediately after accept.
- Throughput: minimum 2 cycles per transaction (WAIT_CYCLES=0, rsp_ready tied 1). No overlap of request and response; a new accept is possible on the edge after the response handshake.
- Backpressure: rsp_valid, rdata and rsp_wr hold stable while rsp_ready=0, indefinitely.
- rsp_ready while rsp_valid=0 is ignored.
- Address: addr is always in range because DEPTH = 2**ADDR_W; there is no out-of-range case. Address 2**ADDR_W-1 is a normal entry.
- Reset mid-transaction (in WAIT or RESP): the in-flight response is dropped and memory clears. A write accepted before the reset is lost.
- X on req_valid while in reset is don't-care.

Optional Feature:
- Macro RAM_RESPONDER_STATS_EN. When defined, two extra output ports are present:
  - wr_count  output  16
  - rd_count  output  16
- Counting rules:
  - Each counter increments on the response handshake edge (rsp_valid & rsp_ready) for its transaction type.
  - Counters wrap from 16'hFFFF to 0.
  - Counters reset to 0 on rst.
- When not defined, the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then with WAIT_CYCLES=0 and rsp_ready=1:
  - Stimulus: write (0,10), (1,20), (3,30), (4,40), then read addresses 0,1,3,4,2.
  - Required: rdata 10,20,30,40,0; each rsp_valid exactly 1 cycle after accept; rsp_wr=1 for writes, 0 for reads.
- WAIT_CYCLES=3, write (7,8'hA5) then read 7:
  - Required: req_ready low for 4 cycles per transaction; rsp_valid rises 4 cycles after accept; rdata=8'hA5.
- Backpressure: read addr 3 (holding 30) with rsp_ready=0 for 5 cycles, then 1:
  - Required: rsp_valid=1 and rdata=30 stable all 5 cycles; req_ready=0 throughout; IDLE on the edge after rsp_ready=1.
- Reset mid-operation:
  - Stimulus: WAIT_CYCLES=3, write (2,55); assert rst in WAIT; release; read 2.
  - Required: rsp_valid=0 immediately on rst; read returns 0.
- Request held while busy:
  - Stimulus: second request with req_valid=1, addr=5, wdata=99 held during RESP of a prior read.
  - Required: not accepted until the handshake completes; then accepted exactly once; a read of 5 returns 99.
- With RAM_RESPONDER_STATS_EN, after scenario 1:
  - Required: wr_count=4, rd_count=5; both 0 after a fresh reset.
